palette_lookup_arbiter: RTL and testbench

Shares one combinational 16-entry palette lookup (4-bit index -> 12-bit RGB) between NUM_REQ pixel requesters, such as background, sprite and HUD layers.
- Round-robin grant, at most one lookup per cycle.
- The granted index drives the palette; the returned RGB is registered into a single response slot with valid/ready backpressure.
- Sits between the layer fetch units and the VGA compositor.

---
 rtl/palette_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/palette_lookup_arbiter.sv | 86 ++++++++
 tb/tb_palette_lookup_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// Shared types and constants for the palette lookup path: the 12-bit colour
// struct, palette geometry and the default requester count.
package palette_pkg;

  localparam int PAL_IDX_W       = 4;
  localparam int PAL_DEPTH       = 16;
  localparam int DEFAULT_NUM_REQ = 4;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb12_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans the request vector starting at the
// rotation pointer, wrapping modulo N, and grants the first set bit.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx,
  output logic          o_any
);

  always_comb begin
    int sel;
    sel         = 0;
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    if (i_en) begin
      for (int k = 0; k < N; k++) begin
        sel = (int'(i_ptr) + k) % N;
        if (!o_any && i_req[IW'(sel)]) begin
          o_any               = 1'b1;
          o_grant_idx         = IW'(sel);
          o_grant[IW'(sel)]   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/palette_lookup_arbiter.sv
// Shares one combinational palette between NUM_REQ requesters with round-robin
// grants and a single registered response slot under valid/ready backpressure.
module palette_lookup_arbiter
  import palette_pkg::*;
#(
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int IDX_W      = PAL_IDX_W,
  parameter bit TRANSP_EN  = 1'b1,
  parameter int TRANSP_IDX = 0,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][IDX_W-1:0]  req_index,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [IDX_W-1:0]               pal_index,
  input  logic [11:0]                    pal_rgb,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [11:0]                    rsp_rgb,
  output logic                           rsp_transparent,
  output logic [15:0]                    lookup_count
);

  localparam logic [IDX_W-1:0] TIDX = IDX_W'(TRANSP_IDX);

  logic [ID_W-1:0]    r_rr_ptr;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  rgb12_t             r_rsp_rgb;
  logic               r_rsp_transp;
  logic [15:0]        r_lookup_count;

  logic               w_slot_free;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_gidx;
  logic               w_any;
  logic [IDX_W-1:0]   w_pal_index;
  logic               w_transp;

  // A new grant may land whenever the slot is empty or is being drained now.
  assign w_slot_free = !r_rsp_valid || rsp_ready;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_req       (req_valid),
    .i_ptr       (r_rr_ptr),
    .i_en        (w_slot_free),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx),
    .o_any       (w_any)
  );

  assign w_pal_index = w_any ? req_index[w_gidx] : '0;
  assign w_transp    = TRANSP_EN && (req_index[w_gidx] == TIDX);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rr_ptr       <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= '0;
      r_rsp_rgb      <= '0;
      r_rsp_transp   <= 1'b0;
      r_lookup_count <= '0;
    end else if (w_any) begin
      r_rsp_valid    <= 1'b1;
      r_rsp_id       <= w_gidx;
      r_rsp_rgb      <= rgb12_t'(pal_rgb);
      r_rsp_transp   <= w_transp;
      r_rr_ptr       <= (w_gidx == ID_W'(NUM_REQ - 1)) ? '0 : w_gidx + ID_W'(1);
      r_lookup_count <= r_lookup_count + 16'd1;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign req_ready       = w_grant;
  assign pal_index       = w_pal_index;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_id          = r_rsp_id;
  assign rsp_rgb         = r_rsp_rgb;
  assign rsp_transparent = r_rsp_transp;
  assign lookup_count    = r_lookup_count;

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Directed bench for palette_lookup_arbiter: a transparency-enabled instance and
// a transparency-disabled twin driven by the same stimulus, each with its own palette.
module tb_palette_lookup_arbiter;

  logic            Clk;
  logic            Reset_n;
  logic [3:0]      req_valid;
  logic [3:0][3:0] req_index;
  logic            rsp_ready;

  logic [3:0]  req_ready,  req_ready_nt;
  logic [3:0]  pal_index,  pal_index_nt;
  logic [11:0] pal_rgb,    pal_rgb_nt;
  logic        rsp_valid,  rsp_valid_nt;
  logic [1:0]  rsp_id,     rsp_id_nt;
  logic [11:0] rsp_rgb,    rsp_rgb_nt;
  logic        rsp_transp, rsp_transp_nt;
  logic [15:0] lookup_count, lookup_count_nt;

  int checks = 0;
  int errors = 0;

  function automatic logic [11:0] palette(input logic [3:0] idx);
    case (idx)
      4'd0:    palette = 12'h7A8;
      4'd1:    palette = 12'h000;
      4'd3:    palette = 12'h6F3;
      4'd4:    palette = 12'hF95;
      4'd5:    palette = 12'h931;
      4'd7:    palette = 12'h493;
      default: palette = {idx, ~idx, idx};
    endcase
  endfunction

  assign pal_rgb    = palette(pal_index);
  assign pal_rgb_nt = palette(pal_index_nt);

  palette_lookup_arbiter #(.NUM_REQ(4), .IDX_W(4), .TRANSP_EN(1'b1), .TRANSP_IDX(0)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req_valid(req_valid), .req_index(req_index),
    .req_ready(req_ready), .pal_index(pal_index), .pal_rgb(pal_rgb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_rgb(rsp_rgb),
    .rsp_transparent(rsp_transp), .lookup_count(lookup_count)
  );

  palette_lookup_arbiter #(.NUM_REQ(4), .IDX_W(4), .TRANSP_EN(1'b0), .TRANSP_IDX(0)) dut_nt (
    .Clk(Clk), .Reset_n(Reset_n), .req_valid(req_valid), .req_index(req_index),
    .req_ready(req_ready_nt), .pal_index(pal_index_nt), .pal_rgb(pal_rgb_nt),
    .rsp_valid(rsp_valid_nt), .rsp_ready(rsp_ready), .rsp_id(rsp_id_nt), .rsp_rgb(rsp_rgb_nt),
    .rsp_transparent(rsp_transp_nt), .lookup_count(lookup_count_nt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    #2;
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_id got %0d want 0", rsp_id); end
    checks++; if (rsp_rgb !== 12'h000) begin errors++; $display("[TB] FAIL reset_rgb got %h want 000", rsp_rgb); end
    checks++; if (rsp_transp !== 1'b0) begin errors++; $display("[TB] FAIL reset_transp got %b want 0", rsp_transp); end
    checks++; if (lookup_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", lookup_count); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ready got %b want 0000", req_ready); end
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge Clk);
    req_valid = 4'b0001;
    req_index = {4'h0, 4'h0, 4'h0, 4'h3};
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_ready got %b want 0001", req_ready); end
    checks++; if (pal_index !== 4'h3) begin errors++; $display("[TB] FAIL single_pal_index got %h want 3", pal_index); end
    @(posedge Clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %b want 1", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL single_id got %0d want 0", rsp_id); end
    checks++; if (rsp_rgb !== 12'h6F3) begin errors++; $display("[TB] FAIL single_rgb got %h want 6F3", rsp_rgb); end
    checks++; if (rsp_transp !== 1'b0) begin errors++; $display("[TB] FAIL single_transp got %b want 0", rsp_transp); end
    checks++; if (lookup_count !== 16'd1) begin errors++; $display("[TB] FAIL single_count got %0d want 1", lookup_count); end
    @(negedge Clk);
    req_valid = 4'b0000;
    #1;
    checks++; if (pal_index !== 4'h0) begin errors++; $display("[TB] FAIL idle_pal_index got %h want 0", pal_index); end
    @(posedge Clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL retire_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_rgb !== 12'h6F3) begin errors++; $display("[TB] FAIL retire_rgb_hold got %h want 6F3", rsp_rgb); end
    checks++; if (dut.r_rr_ptr !== 2'd1) begin errors++; $display("[TB] FAIL single_ptr got %0d want 1", dut.r_rr_ptr); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [11:0] exp_rgb [5] = '{12'h000, 12'hF95, 12'h931, 12'h493, 12'h000};
    do_reset();
    @(negedge Clk);
    req_valid = 4'b1111;
    req_index = {4'h7, 4'h5, 4'h4, 4'h1};
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (req_ready !== (4'b0001 << exp_id[i])) begin errors++; $display("[TB] FAIL rr_ready[%0d] got %b want %b", i, req_ready, 4'b0001 << exp_id[i]); end
      @(posedge Clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id[i]) begin errors++; $display("[TB] FAIL rr_id[%0d] got v=%b id=%0d want v=1 id=%0d", i, rsp_valid, rsp_id, exp_id[i]); end
      checks++; if (rsp_rgb !== exp_rgb[i]) begin errors++; $display("[TB] FAIL rr_rgb[%0d] got %h want %h", i, rsp_rgb, exp_rgb[i]); end
      @(negedge Clk);
    end
    checks++; if (lookup_count !== 16'd5) begin errors++; $display("[TB] FAIL rr_count got %0d want 5", lookup_count); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (req_ready !== 4'b0000 || pal_index !== 4'h0) begin errors++; $display("[TB] FAIL bp_ready[%0d] got %b/%h want 0000/0", i, req_ready, pal_index); end
      @(posedge Clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_rgb !== 12'h000 || lookup_count !== 16'd5) begin
        errors++; $display("[TB] FAIL bp_hold[%0d] got v=%b id=%0d rgb=%h cnt=%0d want 1/0/000/5", i, rsp_valid, rsp_id, rsp_rgb, lookup_count);
      end
      @(negedge Clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL bp_release_ready got %b want 0100", req_ready); end
    @(posedge Clk); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_rgb !== 12'h931) begin errors++; $display("[TB] FAIL bp_release_rsp got v=%b id=%0d rgb=%h want 1/2/931", rsp_valid, rsp_id, rsp_rgb); end
    checks++; if (lookup_count !== 16'd6) begin errors++; $display("[TB] FAIL bp_count got %0d want 6", lookup_count); end
    @(negedge Clk);
    req_valid = 4'b0000;
  endtask

  task automatic test_transparency();
    @(negedge Clk);
    req_valid = 4'b0010;
    req_index = {4'h7, 4'h5, 4'h0, 4'h1};
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL tr_ready got %b want 0010", req_ready); end
    @(posedge Clk); #1;
    checks++; if (rsp_transp !== 1'b1 || rsp_rgb !== 12'h7A8) begin errors++; $display("[TB] FAIL tr_en got t=%b rgb=%h want 1/7A8", rsp_transp, rsp_rgb); end
    checks++; if (rsp_transp_nt !== 1'b0 || rsp_rgb_nt !== 12'h7A8) begin errors++; $display("[TB] FAIL tr_dis got t=%b rgb=%h want 0/7A8", rsp_transp_nt, rsp_rgb_nt); end
    @(negedge Clk);
    req_valid = 4'b0000;
  endtask

  task automatic test_async_reset();
    @(negedge Clk);
    req_valid = 4'b1111;
    req_index = {4'h7, 4'h5, 4'h4, 4'h1};
    rsp_ready = 1'b1;
    repeat (2) @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_rgb !== 12'h000 || rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL ar_rsp got v=%b rgb=%h id=%0d want 0/000/0", rsp_valid, rsp_rgb, rsp_id); end
    checks++; if (lookup_count !== 16'd0 || dut.r_rr_ptr !== 2'd0) begin errors++; $display("[TB] FAIL ar_state got cnt=%0d ptr=%0d want 0/0", lookup_count, dut.r_rr_ptr); end
    @(negedge Clk);
    req_valid = 4'b1100;
    Reset_n = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL ar_first_ready got %b want 0100", req_ready); end
    @(posedge Clk); #1;
    checks++; if (rsp_id !== 2'd2 || lookup_count !== 16'd1) begin errors++; $display("[TB] FAIL ar_first_rsp got id=%0d cnt=%0d want 2/1", rsp_id, lookup_count); end
    @(negedge Clk);
    req_valid = 4'b0000;
  endtask

  task automatic test_counter_wrap();
    do_reset();
    @(negedge Clk);
    req_valid = 4'b1111;
    req_index = {4'h7, 4'h5, 4'h4, 4'h1};
    rsp_ready = 1'b1;
    repeat (65535) @(posedge Clk);
    #1;
    checks++; if (lookup_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_pre got %h want FFFF", lookup_count); end
    @(posedge Clk); #1;
    checks++; if (lookup_count !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_zero got %h want 0000", lookup_count); end
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_rgb !== 12'h493) begin errors++; $display("[TB] FAIL wrap_rsp got v=%b id=%0d rgb=%h want 1/3/493", rsp_valid, rsp_id, rsp_rgb); end
    checks++; if (dut.r_rr_ptr !== 2'd0) begin errors++; $display("[TB] FAIL wrap_ptr got %0d want 0", dut.r_rr_ptr); end
    @(negedge Clk);
    req_valid = 4'b0000;
  endtask

  initial begin
    Reset_n   = 1'b0;
    req_valid = 4'b0000;
    req_index = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_transparency();
    test_async_reset();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
